// File: rtl/pwm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_pkg: shared widths, constants and slew-state type for the     |
// | frame-synchronous PWM pipeline.           Revision: 1.0           |
// +------------------------------------------------------------------+
package pwm_pkg;

  localparam int PWM_CTR_W = 12;
  localparam int Q15_W     = 16;

  localparam logic [Q15_W-1:0] Q15_OFFSET = 16'h8000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SLEW_UP = 2'd1,
    SLEW_DN = 2'd2
  } slew_state_e;

endpackage
`default_nettype wire

// File: rtl/q15_duty_shaper_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | q15_duty_shaper_if: valid/ready sample stream into the shaper.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface q15_duty_shaper_if #(
  parameter int IN_W = pwm_pkg::Q15_W
) ();

  logic            s_valid;
  logic            s_ready;
  logic [IN_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface
`default_nettype wire

// File: rtl/pwm_frame_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_frame_timer: free-running mirror of the PWM phase counter;    |
// | flags the last cycle of a frame and the first. Revision: 1.0      |
// +------------------------------------------------------------------+
module pwm_frame_timer #(
  parameter int CTR_W = pwm_pkg::PWM_CTR_W
) (
  input  logic clk,
  input  logic rst,
  output logic boundary,
  output logic frame_start
);

  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             frame_start_q, frame_start_d;

  assign boundary = &ctr_q;

  always_comb begin
    ctr_d         = ctr_q + CTR_W'(1);
    frame_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      ctr_q         <= ctr_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: rtl/q15_duty_shaper.sv
`default_nettype none
// +------------------------------------------------------------------+
// | q15_duty_shaper: Q1.15 samples -> rate-limited offset-binary duty |
// | updated only at frame starts. Optional: Q15_DUTY_SHAPER_DITHER_EN |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module q15_duty_shaper
  import pwm_pkg::*;
#(
  parameter int CTR_W      = PWM_CTR_W,
  parameter int IN_W       = Q15_W,
  parameter int STEP_MAX   = 64,
  parameter int DUTY_MAX   = (1 << CTR_W) - 1,
  parameter int RESET_DUTY = 0
) (
  input  logic             clk,
  input  logic             rst,
  q15_duty_shaper_if.slave s_if,
  output logic [CTR_W-1:0] duty,
  output logic             duty_upd,
  output logic             at_target,
  output logic             frame_start
);

  localparam int               FRAC_W     = IN_W - CTR_W;
  localparam logic [IN_W-1:0]  MSB_FLIP   = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [IN_W:0]    DUTY_MAX_W = (IN_W+1)'(DUTY_MAX);
  localparam logic [CTR_W-1:0] DUTY_MAX_C = CTR_W'(DUTY_MAX);
  localparam logic [CTR_W:0]   STEP_C     = (CTR_W+1)'(STEP_MAX);
  localparam logic [CTR_W-1:0] RESET_C    = CTR_W'(RESET_DUTY);

  logic             boundary;
  logic             accept;
  logic             ready_q, ready_d;
  logic [CTR_W-1:0] target_q, target_d;
  logic [CTR_W-1:0] slew_q, slew_d;
  logic [CTR_W-1:0] duty_q, duty_d;
  logic             duty_upd_q, duty_upd_d;
  logic             at_target_q, at_target_d;
  slew_state_e      state_q, state_d;
  logic [IN_W-1:0]  u;
  logic [IN_W:0]    r;
  logic [CTR_W-1:0] target_conv;
  logic [CTR_W:0]   diff;
  logic [CTR_W-1:0] step;
`ifdef Q15_DUTY_SHAPER_DITHER_EN
  logic [FRAC_W-1:0] frac_q, frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;
`endif

  pwm_frame_timer #(.CTR_W(CTR_W)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .boundary    (boundary),
    .frame_start (frame_start)
  );

  // Target may not move in the boundary cycle while the slew step is formed.
  assign s_if.s_ready = ready_q && !boundary;

  always_comb begin
    u = s_if.s_data ^ MSB_FLIP;
`ifdef Q15_DUTY_SHAPER_DITHER_EN
    r = {1'b0, u} >> FRAC_W;
`else
    r = ({1'b0, u} + (IN_W+1)'(1 << (FRAC_W-1))) >> FRAC_W;
`endif
    target_conv = (r > DUTY_MAX_W) ? DUTY_MAX_C : r[CTR_W-1:0];
  end

  always_comb begin
    accept   = s_if.s_valid && s_if.s_ready;
    ready_d  = 1'b1;
    target_d = accept ? target_conv : target_q;

    diff = (state_q == SLEW_DN) ? ({1'b0, slew_q} - {1'b0, target_q})
                                : ({1'b0, target_q} - {1'b0, slew_q});
    step = (diff > STEP_C) ? STEP_C[CTR_W-1:0] : diff[CTR_W-1:0];

    slew_d = slew_q;
    if (boundary) begin
      case (state_q)
        SLEW_UP: slew_d = slew_q + step;
        SLEW_DN: slew_d = slew_q - step;
        default: slew_d = slew_q;
      endcase
    end

    if (target_d > slew_d) begin
      state_d = SLEW_UP;
    end else if (target_d < slew_d) begin
      state_d = SLEW_DN;
    end else begin
      state_d = IDLE;
    end
    at_target_d = (target_d == slew_d);

`ifdef Q15_DUTY_SHAPER_DITHER_EN
    // The +1 lasts one frame; the slewed value underneath is left untouched.
    frac_d  = accept ? u[FRAC_W-1:0] : frac_q;
    acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
    acc_d   = acc_q;
    duty_d  = duty_q;
    if (boundary) begin
      acc_d  = acc_sum[FRAC_W-1:0];
      duty_d = (acc_sum[FRAC_W] && (slew_d < DUTY_MAX_C)) ? slew_d + CTR_W'(1) : slew_d;
    end
`else
    duty_d = slew_d;
`endif
    duty_upd_d = boundary && (duty_d != duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      target_q    <= RESET_C;
      slew_q      <= RESET_C;
      duty_q      <= RESET_C;
      duty_upd_q  <= 1'b0;
      at_target_q <= 1'b1;
      state_q     <= IDLE;
`ifdef Q15_DUTY_SHAPER_DITHER_EN
      frac_q      <= '0;
      acc_q       <= '0;
`endif
    end else begin
      ready_q     <= ready_d;
      target_q    <= target_d;
      slew_q      <= slew_d;
      duty_q      <= duty_d;
      duty_upd_q  <= duty_upd_d;
      at_target_q <= at_target_d;
      state_q     <= state_d;
`ifdef Q15_DUTY_SHAPER_DITHER_EN
      frac_q      <= frac_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign duty      = duty_q;
  assign duty_upd  = duty_upd_q;
  assign at_target = at_target_q;

endmodule
`default_nettype wire

// File: doc/q15_duty_shaper.md
Name: q15_duty_shaper

Overview:
- Upstream stage of the 12-bit PWM DAC and fan PWM core.
- Accepts signed Q1.15 samples over a valid/ready handshake and maps them to offset-binary duty.
- Rate-limits duty changes to at most STEP_MAX counts per PWM frame.
- Updates duty only at frame boundaries, using an internal frame counter that mirrors the PWM core's phase counter. Both blocks share clk and rst, so they stay phase-aligned.

Parameters:
- CTR_W, 12: duty width; PWM frame = 2^CTR_W clocks; must equal the downstream PWM CTR_W.
- IN_W, 16: input sample width (Q1.(IN_W-1)); must be greater than CTR_W.
- STEP_MAX, 64: maximum duty change per frame; valid range 1..2^CTR_W-1.
- DUTY_MAX, 2^CTR_W-1: upper clamp on target duty.
- RESET_DUTY, 0: duty value loaded on reset.

Ports:
- clk, in, 1: fabric clock.
- rst, in, 1: synchronous, active-high reset.
- s_valid, in, 1: input sample valid.
- s_ready, out, 1: input ready; transfer occurs when s_valid && s_ready.
- s_data, in, IN_W: signed Q1.15 sample.
- duty, out, CTR_W: registered duty to the PWM core.
- duty_upd, out, 1: one-cycle pulse, asserted when duty changed at this frame start.
- at_target, out, 1: high when duty == target.
- frame_start, out, 1: one-cycle pulse, asserted when the mirror counter equals 0.

Behaviour:
- Mirror counter ctr (CTR_W bits):
  - Reset value 0; increments every clock; wraps modulo 2^CTR_W.
  - Boundary cycle = cycle where ctr == 2^CTR_W-1.
- Reset (any cycle, including mid-slew):
  - ctr=0, duty=RESET_DUTY, target=RESET_DUTY, state=IDLE.
  - duty_upd=0, frame_start=0, at_target=1, s_ready=0.
  - s_ready rises on the first clock after rst deasserts.
- Handshake:
  - s_ready=1 in all non-reset cycles except the boundary cycle. There it is 0, so target cannot change while the slew step is evaluated.
  - While stalled, the producer holds s_valid and s_data.
  - A transfer writes target on the next edge; one-cycle accept latency.
  - Back-to-back transfers allowed; the last accepted sample before the boundary wins.
- Conversion (non-dither build):
  - u = s_data with MSB inverted (offset binary, unsigned IN_W).
  - r = (u + 2^(IN_W-CTR_W-1)) >> (IN_W-CTR_W), computed at IN_W+1 bits.
  - target = min(r, DUTY_MAX).
- States:
  - IDLE (duty==target), SLEW_UP (target>duty), SLEW_DN (target<duty).
  - State is re-evaluated every cycle from target vs duty.
- Slew step, evaluated in the boundary cycle and registered on the edge where ctr wraps to 0:
  - SLEW_UP: duty += min(target-duty, STEP_MAX).
  - SLEW_DN: duty -= min(duty-target, STEP_MAX).
  - IDLE: duty unchanged.
  - Arithmetic is CTR_W+1 bits, with no wrap at 0 or 2^CTR_W-1.
- duty_upd is asserted in the cycle ctr==0 only if duty changed on that edge.
- at_target and frame_start are registered.
- duty never changes outside a frame start, so each PWM frame sees a single duty value.
- A target change during a slew takes effect at the next boundary; direction may reverse mid-slew.

Optional Feature:
- Macro: Q15_DUTY_SHAPER_DITHER_EN.
- When defined:
  - Conversion truncates instead of rounding.
  - The low IN_W-CTR_W fraction bits are kept in target_frac.
  - A frac accumulator of IN_W-CTR_W bits, reset 0, adds target_frac at each boundary.
  - On carry-out, duty is driven as (slewed value + 1) for that frame only, saturating at DUTY_MAX. The slewed state itself is unaffected.
  - at_target compares the slewed value, not the dithered one.
- When undefined: no accumulator; rounding conversion as above.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CTR_W=12 and Q15_W=16 constants.
  - Slew-state enum {IDLE, SLEW_UP, SLEW_DN}.
  - Q15 offset constant 16'h8000.
- One sub-module: pwm_frame_timer.
  - Contains the mirror counter.
  - Outputs boundary and frame_start pulses.
  - Reusable by other frame-synchronous stages.

Test Plan:
- Reset, then idle 2 frames -> duty=0, at_target=1, duty_upd never asserted, frame_start every 4096 clocks.
- s_data=16'h0000 accepted -> target=2048; duty steps 64,128,…,2048 at 32 consecutive frame starts with duty_upd each time; at_target=1 after the 32nd step; duty is constant between boundaries.
- s_data=16'h7FFF -> target=4095 (rounded result 4096 saturates). s_data=16'h8000 -> target=0; duty ramps down by 64 per frame and reaches exactly 0 with no underflow.
- duty=2048, s_data=16'h0100 -> target=2064; single step to 2064 at the next frame start; reversing to 16'hFF00 (target 2032) mid-ramp lands in 1 step.
- s_valid asserted in the boundary cycle (ctr=4095) -> s_ready=0, no transfer; transfer on the next cycle; that frame's slew step uses the old target.
- rst pulsed mid-slew at duty=1000 -> next cycle duty=0, ctr=0, at_target=1. With Q15_DUTY_SHAPER_DITHER_EN, s_data=16'h0008 (frac=8/16) -> duty alternates 2048/2049 on successive frames once the slew reaches 2048.
